// File: rtl/add_reg_mul_checker.sv
// add_reg_mul_checker
//
// Cycle-accurate response monitor for the add_reg_mul datapath
// (y = c + R, with R <= a*b on en, everything truncated to WIDTH).
// It watches the same a/b/c/en stimulus as the datapath and compares the
// datapath's y against its own golden model on every compare cycle. It also
// keeps sticky pass/fail/done status plus first-mismatch diagnostics.
//
// Ports
//   clock            : sole clock, rising edge
//   reset            : asynchronous, active-low
//   a, b, c, en      : stimulus as driven to the datapath under check
//   y                : datapath output under check
//   expected         : combinational golden value c + R_model (mod 2^WIDTH)
//   checking         : high while compares are being run (CHECK state)
//   done             : sticky, all compares finished (or stopped on failure)
//   pass             : sticky, done with zero mismatches
//   fail             : sticky, at least one mismatch seen
//   mismatch_count   : mismatching compares, saturating at 16'hFFFF
//   first_fail_index : 0-based compare index of the first mismatch
//   first_fail_y     : y captured at the first mismatch
module add_reg_mul_checker #(
    parameter int WIDTH        = 8,
    parameter int SKIP         = 1,
    parameter int NUM_CHECKS   = 2,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             en,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] expected,
    output logic             checking,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [15:0]      mismatch_count,
    output logic [15:0]      first_fail_index,
    output logic [WIDTH-1:0] first_fail_y
);

    localparam logic [1:0] WARMUP = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] FAIL   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    // Warm-up ends on the edge where the counter shows SKIP-1.
    localparam logic [3:0]  SKIP_LAST = (SKIP == 0) ? 4'd0 : 4'(SKIP - 1);
    localparam logic [15:0] NUM_LAST  = 16'(NUM_CHECKS);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]       state;
    logic [3:0]       skip_cnt;
    logic [15:0]      cmp_idx;
    logic [15:0]      idx_next;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] prod_p1;
    logic             do_cmp;
    logic             miss;

    // Low WIDTH bits of the full-width product are exactly the WIDTH-bit product.
    assign prod_lo  = a * b;
    assign expected = c + prod_p1;

    always_comb begin
        // With no warm-up, the very first edge out of reset is already a compare.
        do_cmp   = (state == CHECK) || ((state == WARMUP) && (SKIP == 0));
        // Case inequality so X/Z on y is reported as a mismatch.
        miss     = do_cmp && (y !== expected);
        idx_next = cmp_idx + 16'd1;
    end

    // Stage p1: golden product register and checker state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prod_p1          <= '0;
            state            <= WARMUP;
            skip_cnt         <= 4'd0;
            cmp_idx          <= 16'd0;
            checking         <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            fail             <= 1'b0;
            mismatch_count   <= 16'd0;
            first_fail_index <= 16'd0;
            first_fail_y     <= '0;
        end else begin
            // The model keeps tracking the stimulus even after checking ends.
            if (en) begin
                prod_p1 <= prod_lo;
            end

            if (do_cmp) begin
                if (miss) begin
                    mismatch_count <= sat_inc16(mismatch_count);
                    if (!fail) begin
                        fail             <= 1'b1;
                        first_fail_index <= cmp_idx;
                        first_fail_y     <= y;
                    end
                end
                cmp_idx <= idx_next;

                if (STOP_ON_FAIL && miss) begin
                    state    <= FAIL;
                    checking <= 1'b0;
                    done     <= 1'b1;
                    pass     <= 1'b0;
                end else if (idx_next == NUM_LAST) begin
                    state    <= DONE;
                    checking <= 1'b0;
                    done     <= 1'b1;
                    pass     <= ~(fail | miss);
                end else begin
                    state    <= CHECK;
                    checking <= 1'b1;
                end
            end else if (state == WARMUP) begin
                if (skip_cnt == SKIP_LAST) begin
                    state    <= CHECK;
                    checking <= 1'b1;
                end else begin
                    skip_cnt <= skip_cnt + 4'd1;
                end
            end
            // FAIL and DONE are terminal: status and counters hold.
        end
    end

endmodule

// File: tb/tb_add_reg_mul_checker.sv
// Directed bench for add_reg_mul_checker. Two instances share stimulus:
//   u0 : SKIP=1, NUM_CHECKS=2, STOP_ON_FAIL=1
//   u1 : SKIP=0, NUM_CHECKS=4, STOP_ON_FAIL=0
module tb_add_reg_mul_checker;

    logic       clock;
    logic       reset;
    logic [7:0] a, b, c;
    logic       en;
    logic [7:0] y0, y1;

    logic [7:0]  exp0, exp1, ffy0, ffy1;
    logic        chk0, chk1, done0, done1, pass0, pass1, fail0, fail1;
    logic [15:0] mm0, mm1, ffi0, ffi1;

    int total = 0;
    int bad   = 0;

    add_reg_mul_checker #(.WIDTH(8), .SKIP(1), .NUM_CHECKS(2), .STOP_ON_FAIL(1'b1)) u0 (
        .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .en(en), .y(y0),
        .expected(exp0), .checking(chk0), .done(done0), .pass(pass0), .fail(fail0),
        .mismatch_count(mm0), .first_fail_index(ffi0), .first_fail_y(ffy0)
    );

    add_reg_mul_checker #(.WIDTH(8), .SKIP(0), .NUM_CHECKS(4), .STOP_ON_FAIL(1'b0)) u1 (
        .clock(clock), .reset(reset), .a(a), .b(b), .c(c), .en(en), .y(y1),
        .expected(exp1), .checking(chk1), .done(done1), .pass(pass1), .fail(fail1),
        .mismatch_count(mm1), .first_fail_index(ffi1), .first_fail_y(ffy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Advance past the next rising edge; sampling happens 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Enter reset from edge+1, release on the following falling edge.
    task automatic do_reset(input logic [7:0] na, input logic [7:0] nb,
                            input logic [7:0] nc, input logic nen,
                            input logic [7:0] ny0, input logic [7:0] ny1);
        reset = 1'b0;
        a = na; b = nb; c = nc; en = nen; y0 = ny0; y1 = ny1;
        #4;
        reset = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        a = 8'd4; b = 8'd2; c = 8'd3; en = 1'b1; y0 = 8'd3; y1 = 8'd3;
        #2;
        chk("rst_expected", 16'(exp0), 16'd3);
        chk("rst_checking", 16'(chk0), 16'd0);
        chk("rst_done", 16'(done0), 16'd0);
        chk("rst_pass", 16'(pass0), 16'd0);
        chk("rst_fail", 16'(fail0), 16'd0);
        chk("rst_mm", mm0, 16'd0);
        #10;
        chk("rst_hold_expected", 16'(exp0), 16'd3);
        reset = 1'b1;

        // ---------------- phase 1: u0 clean pass, u1 fails on compares 1,3 ----------------
        tick();                                   // u0 warm-up edge, u1 compare 0 ok
        a = 8'd0; b = 8'd0; en = 1'b0; y0 = 8'd11; y1 = 8'd99;
        chk("p1_expected_11", 16'(exp0), 16'd11);
        chk("p1_u0_checking", 16'(chk0), 16'd1);
        chk("p1_u0_not_done", 16'(done0), 16'd0);
        chk("p1_u1_cmp0_ok", mm1, 16'd0);
        tick();                                   // u0 cmp0, u1 cmp1 wrong
        y1 = 8'd11;
        chk("p1_u1_mm1", mm1, 16'd1);
        chk("p1_u1_fail", 16'(fail1), 16'd1);
        chk("p1_u1_ffi", ffi1, 16'd1);
        chk("p1_u1_ffy", 16'(ffy1), 16'd99);
        chk("p1_u1_still_checking", 16'(chk1), 16'd1);
        chk("p1_u0_mid_done", 16'(done0), 16'd0);
        tick();                                   // u0 cmp1 -> DONE, u1 cmp2 ok
        y1 = 8'd0;
        chk("p1_u0_done", 16'(done0), 16'd1);
        chk("p1_u0_pass", 16'(pass0), 16'd1);
        chk("p1_u0_fail", 16'(fail0), 16'd0);
        chk("p1_u0_mm", mm0, 16'd0);
        chk("p1_u0_checking_off", 16'(chk0), 16'd0);
        chk("p1_u1_not_done", 16'(done1), 16'd0);
        tick();                                   // u1 cmp3 wrong -> DONE with fail
        chk("p1_u1_mm2", mm1, 16'd2);
        chk("p1_u1_ffi_kept", ffi1, 16'd1);
        chk("p1_u1_ffy_kept", 16'(ffy1), 16'd99);
        chk("p1_u1_done", 16'(done1), 16'd1);
        chk("p1_u1_pass", 16'(pass1), 16'd0);
        tick();                                   // terminal: y1 still wrong, nothing moves
        chk("p1_u1_frozen_mm", mm1, 16'd2);
        chk("p1_u0_frozen_pass", 16'(pass0), 16'd1);

        // ---------------- phase 2: u0 stop on fail ----------------
        do_reset(8'd4, 8'd2, 8'd3, 1'b1, 8'd3, 8'd3);
        chk("p2_rst_done_cleared", 16'(done0), 16'd0);
        chk("p2_rst_u1_mm_cleared", mm1, 16'd0);
        tick();
        a = 8'd0; b = 8'd0; en = 1'b0; y0 = 8'd11; y1 = 8'd11;
        tick();                                   // u0 cmp0 ok
        y0 = 8'd10;
        chk("p2_u0_cmp0_ok", 16'(fail0), 16'd0);
        tick();                                   // u0 cmp1 wrong -> FAIL
        y0 = 8'd0;
        chk("p2_u0_fail", 16'(fail0), 16'd1);
        chk("p2_u0_done", 16'(done0), 16'd1);
        chk("p2_u0_pass", 16'(pass0), 16'd0);
        chk("p2_u0_ffi", ffi0, 16'd1);
        chk("p2_u0_ffy", 16'(ffy0), 16'd10);
        chk("p2_u0_mm", mm0, 16'd1);
        chk("p2_u0_checking_off", 16'(chk0), 16'd0);
        tick();
        chk("p2_u0_frozen_mm", mm0, 16'd1);
        chk("p2_u0_frozen_ffy", 16'(ffy0), 16'd10);
        chk("p2_u1_pass", 16'(pass1), 16'd1);
        chk("p2_u1_done", 16'(done1), 16'd1);

        // ---------------- phase 3: wrap-around ----------------
        do_reset(8'd16, 8'd17, 8'd250, 1'b1, 8'd250, 8'd250);
        tick();                                   // R = 272 mod 256 = 16
        en = 1'b0; y0 = 8'd10; y1 = 8'd10;
        chk("p3_expected_wrap", 16'(exp0), 16'd10);
        tick();
        tick();
        chk("p3_u0_pass", 16'(pass0), 16'd1);
        chk("p3_u0_mm", mm0, 16'd0);
        tick();
        chk("p3_u1_pass", 16'(pass1), 16'd1);

        // ---------------- phase 4: en=0 holds R ----------------
        do_reset(8'd4, 8'd2, 8'd1, 1'b1, 8'd1, 8'd1);
        tick();                                   // R = 8
        en = 1'b0; y0 = 8'd9; y1 = 8'd9; a = 8'd7; b = 8'd9;
        chk("p4_hold_0", 16'(exp0), 16'd9);
        tick();
        a = 8'd255; b = 8'd255;
        chk("p4_hold_1", 16'(exp0), 16'd9);
        chk("p4_hold_1_u1", 16'(exp1), 16'd9);
        tick();
        a = 8'd3; b = 8'd5;
        chk("p4_hold_2", 16'(exp0), 16'd9);
        chk("p4_u0_pass", 16'(pass0), 16'd1);
        tick();
        chk("p4_hold_3", 16'(exp1), 16'd9);
        chk("p4_u1_pass", 16'(pass1), 16'd1);

        // ---------------- phase 5: async reset while failing in CHECK ----------------
        do_reset(8'd4, 8'd2, 8'd3, 1'b1, 8'd3, 8'd0);
        tick();                                   // u1 cmp0 wrong, stays in CHECK
        chk("p5_u1_fail_pre", 16'(fail1), 16'd1);
        chk("p5_u1_checking_pre", 16'(chk1), 16'd1);
        reset = 1'b0;
        #1;
        chk("p5_async_fail", 16'(fail1), 16'd0);
        chk("p5_async_mm", mm1, 16'd0);
        chk("p5_async_checking", 16'(chk1), 16'd0);
        chk("p5_async_done", 16'(done1), 16'd0);
        chk("p5_async_ffi", ffi1, 16'd0);
        chk("p5_async_ffy", 16'(ffy1), 16'd0);
        chk("p5_async_expected", 16'(exp1), 16'd3);
        #3;
        reset = 1'b1;
        y1 = 8'd3;
        tick();                                   // u1 cmp0 ok, R = 8
        en = 1'b0; y0 = 8'd11; y1 = 8'd11;
        chk("p5_restart_fail", 16'(fail1), 16'd0);
        tick();
        tick();
        chk("p5_u0_pass", 16'(pass0), 16'd1);
        tick();
        chk("p5_u1_pass", 16'(pass1), 16'd1);
        chk("p5_u1_fail", 16'(fail1), 16'd0);
        chk("p5_u1_mm", mm1, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
